// File: rtl/fp_add_arbiter_if.sv
// Bundles the requester, fpAdd and response signals of the fpAdd arbiter.
interface fp_add_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 8
);
    localparam int unsigned CNT_W = $clog2(ADD_LATENCY + 2) + 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [31:0]           add_value1;
    logic [31:0]           add_value2;
    logic [31:0]           add_result;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;
    logic [CNT_W-1:0]      in_flight;

    // Client side: drives operands and the fpAdd result.
    modport master (
        output req_valid, req_a, req_b, add_result,
        input  req_ready, add_value1, add_value2, resp_valid, resp_data, in_flight
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, add_result,
        output req_ready, add_value1, add_value2, resp_valid, resp_data, in_flight
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one fixed-latency fpAdd core between NUM_REQ requesters;
// a tag pipeline tracks the owner of every in-flight add.
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 8,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    fp_add_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(ADD_LATENCY + 2) + 1;

    logic [ID_W-1:0]                  r_ptr;
    logic [ADD_LATENCY:0]             r_tag_v;
    logic [ADD_LATENCY:0][ID_W-1:0]   r_tag_id;
    logic [31:0]                      r_add_v1;
    logic [31:0]                      r_add_v2;
    logic [NUM_REQ-1:0]               r_resp_valid;
    logic [31:0]                      r_resp_data;
    logic [CNT_W-1:0]                 r_in_flight;

    logic                             w_issue;
    logic [ID_W-1:0]                  w_gnt_id;
    logic [NUM_REQ-1:0]               w_gnt;
    logic                             w_ret;

    // Search upward from pointer+1, wrapping; first asserted valid wins.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_issue  = 1'b0;
        w_gnt_id = '0;
        w_gnt    = '0;
        if (enable) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = (32'(r_ptr) + k) % NUM_REQ;
                if (!w_issue && bus.req_valid[idx]) begin
                    w_issue  = 1'b1;
                    w_gnt_id = ID_W'(idx);
                end
            end
        end
        if (w_issue) w_gnt = NUM_REQ'(1) << w_gnt_id;
    end

    assign w_ret = r_tag_v[ADD_LATENCY];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr        <= ID_W'(NUM_REQ - 1);
            r_tag_v      <= '0;
            r_tag_id     <= '0;
            r_add_v1     <= '0;
            r_add_v2     <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_in_flight  <= '0;
        end else begin
            // Idle cycles feed 0+0 with an invalid tag so its result is dropped.
            r_tag_v  <= {r_tag_v[ADD_LATENCY-1:0], w_issue};
            r_tag_id <= {r_tag_id[ADD_LATENCY-1:0], w_gnt_id};
            if (w_issue) begin
                r_ptr    <= w_gnt_id;
                r_add_v1 <= bus.req_a[w_gnt_id*32 +: 32];
                r_add_v2 <= bus.req_b[w_gnt_id*32 +: 32];
            end else begin
                r_add_v1 <= '0;
                r_add_v2 <= '0;
            end

            r_resp_valid <= w_ret ? (NUM_REQ'(1) << r_tag_id[ADD_LATENCY]) : '0;
            if (w_ret) r_resp_data <= bus.add_result;

            case ({w_issue, w_ret})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign bus.req_ready  = w_gnt;
    assign bus.add_value1 = r_add_v1;
    assign bus.add_value2 = r_add_v2;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.in_flight  = r_in_flight;
endmodule
